// File: rtl/id_operand_stage.sv
// id_operand_stage
//   IF->ID pipeline register plus per-read-port operand resolution with
//   NSRC bypass sources, load-use interlock and stall-safe operand capture.
//   While an instruction is held in ID, each resolved operand is latched.
//   A bypass source that retires during the stall therefore cannot be lost.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   flush             discard the ID instruction
//   id_hold           downstream stall; ID keeps its instruction
//   if_valid/pc/inst  instruction offered by IF
//   rd_addr, rd_use   decoder read addresses and per-port consume flags
//   rf_rdata          regfile combinational read data
//   byp_*             bypass sources; index 0 is youngest (EX)
//   id_valid/pc/inst  ID pipeline register
//   opnd              resolved operands, port k = [k*DW +: DW]
//   ex_valid          instruction may issue this cycle
//   stallreq          load-use interlock request
//   lu_stall_cnt      number of interlock cycles (wraps)

// Per-read-port resolution plus capture register.
module id_opnd_port #(
  parameter int NSRC = 3,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cap_clr,
  input  logic               cap_en,
  input  logic [AW-1:0]      addr,
  input  logic [DW-1:0]      rf,
  input  logic [NSRC-1:0]    byp_we,
  input  logic [NSRC-1:0]    byp_ready,
  input  logic [NSRC*AW-1:0] byp_waddr,
  input  logic [NSRC*DW-1:0] byp_wdata,
  output logic [DW-1:0]      opnd,
  output logic               pending
);
  logic          cap_v;
  logic [DW-1:0] cap_d;
  logic          hit, hit_rdy;
  logic [DW-1:0] hit_d;

  // First (youngest) matching source wins; older matches are ignored even
  // when the youngest one is not ready yet.
  always_comb begin
    hit     = 1'b0;
    hit_rdy = 1'b0;
    hit_d   = '0;
    for (int s = 0; s < NSRC; s++) begin
      if (!hit && byp_we[s] && (byp_waddr[s*AW +: AW] == addr)) begin
        hit     = 1'b1;
        hit_rdy = byp_ready[s];
        hit_d   = byp_wdata[s*DW +: DW];
      end
    end
  end

  always_comb begin
    opnd    = rf;
    pending = 1'b0;
    if (addr == '0) begin
      opnd = '0;
    end else if (cap_v) begin
      opnd = cap_d;
    end else if (hit) begin
      opnd    = hit_d;
      pending = ~hit_rdy;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_v <= 1'b0;
      cap_d <= '0;
    end else if (cap_clr) begin
      cap_v <= 1'b0;
    end else if (cap_en && !cap_v && !pending) begin
      cap_v <= 1'b1;
      cap_d <= opnd;
    end
  end
endmodule

module id_operand_stage #(
  parameter int          NRD      = 2,
  parameter int          NSRC     = 3,
  parameter int          DW       = 32,
  parameter int          AW       = 5,
  parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               id_hold,
  input  logic               if_valid,
  input  logic [31:0]        if_pc,
  input  logic [31:0]        if_inst,
  input  logic [NRD*AW-1:0]  rd_addr,
  input  logic [NRD-1:0]     rd_use,
  input  logic [NRD*DW-1:0]  rf_rdata,
  input  logic [NSRC-1:0]    byp_we,
  input  logic [NSRC-1:0]    byp_ready,
  input  logic [NSRC*AW-1:0] byp_waddr,
  input  logic [NSRC*DW-1:0] byp_wdata,
  output logic               id_valid,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_inst,
  output logic [NRD*DW-1:0]  opnd,
  output logic               ex_valid,
  output logic               stallreq,
  output logic [31:0]        lu_stall_cnt
);
  logic [NRD-1:0] pending;
  logic           adv;
  logic           cap_clr, cap_en;

  assign adv      = ~id_hold & ~stallreq;
  assign stallreq = id_valid & |(rd_use & pending);
  assign ex_valid = id_valid & ~stallreq;

  // Captures clear whenever ID changes contents; they load only while the
  // same live instruction is held over the edge.
  assign cap_clr = flush | adv;
  assign cap_en  = id_valid & ~adv & ~flush;

  for (genvar k = 0; k < NRD; k++) begin : g_port
    id_opnd_port #(.NSRC(NSRC), .DW(DW), .AW(AW)) u_port (
      .clk      (clk),
      .rst      (rst),
      .cap_clr  (cap_clr),
      .cap_en   (cap_en),
      .addr     (rd_addr[k*AW +: AW]),
      .rf       (rf_rdata[k*DW +: DW]),
      .byp_we   (byp_we),
      .byp_ready(byp_ready),
      .byp_waddr(byp_waddr),
      .byp_wdata(byp_wdata),
      .opnd     (opnd[k*DW +: DW]),
      .pending  (pending[k])
    );
  end

  // Flush keeps pc/inst so debug still sees the squashed instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_valid <= 1'b0;
      id_pc    <= RESET_PC;
      id_inst  <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (adv) begin
      id_valid <= if_valid;
      id_pc    <= if_pc;
      id_inst  <= if_inst;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          lu_stall_cnt <= '0;
    else if (stallreq) lu_stall_cnt <= lu_stall_cnt + 32'd1;
  end
endmodule

// File: tb/tb_id_operand_stage.sv
module tb_id_operand_stage;
  localparam logic [31:0] RPC = 32'hBFBF_FFFC;
  localparam logic [31:0] B   = 32'hBFC0_0000;

  typedef struct {
    logic            fl, hd, iv;
    logic [31:0]     pc;
    logic [1:0][4:0] ra;
    logic [1:0]      ru;
    logic [1:0][31:0] rf;
    logic [2:0]      we, rdy;
    logic [2:0][4:0] wa;
    logic [2:0][31:0] wd;
    logic            e_idv, e_st, e_exv;
    logic [31:0]     e_pc, e_inst, e_cnt;
    logic [1:0]      e_chk;
    logic [1:0][31:0] e_op;
  } vec_t;

  logic        clk = 1'b0, rst = 1'b0;
  logic        flush = 1'b0, id_hold = 1'b0, if_valid = 1'b0;
  logic [31:0] if_pc = '0, if_inst = '0;
  logic [9:0]  rd_addr = '0;
  logic [1:0]  rd_use = '0;
  logic [63:0] rf_rdata = '0;
  logic [2:0]  byp_we = '0, byp_ready = '0;
  logic [14:0] byp_waddr = '0;
  logic [95:0] byp_wdata = '0;
  logic        id_valid, ex_valid, stallreq;
  logic [31:0] id_pc, id_inst, lu_stall_cnt;
  logic [63:0] opnd;

  int tests = 0, fails = 0;
  vec_t tv[$];
  vec_t v;

  id_operand_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .id_hold(id_hold),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .rd_addr(rd_addr), .rd_use(rd_use), .rf_rdata(rf_rdata),
    .byp_we(byp_we), .byp_ready(byp_ready), .byp_waddr(byp_waddr),
    .byp_wdata(byp_wdata), .id_valid(id_valid), .id_pc(id_pc),
    .id_inst(id_inst), .opnd(opnd), .ex_valid(ex_valid),
    .stallreq(stallreq), .lu_stall_cnt(lu_stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [31:0] p);
    return p ^ 32'h1357_9BDF;
  endfunction

  // Default record: IF offers pc, ID expected live at epc, no reads.
  function automatic vec_t nv(input logic [31:0] pc, input logic [31:0] epc);
    vec_t r;
    r = '{default: '0};
    r.iv = 1'b1; r.pc = pc; r.ru = 2'b11;
    r.e_idv = 1'b1; r.e_exv = 1'b1; r.e_pc = epc; r.e_inst = ins(epc);
    r.e_chk = 2'b11;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    flush = x.fl; id_hold = x.hd; if_valid = x.iv;
    if_pc = x.pc; if_inst = ins(x.pc);
    rd_addr = x.ra; rd_use = x.ru; rf_rdata = x.rf;
    byp_we = x.we; byp_ready = x.rdy; byp_waddr = x.wa; byp_wdata = x.wd;
  endtask

  initial begin
    // c0: first cycle after reset; ID empty
    v = nv(B, RPC); v.e_idv = 0; v.e_exv = 0; v.e_inst = 0; tv.push_back(v);
    // c1: addu r3,r1,r2 in ID, regfile operands
    v = nv(B+4, B); v.ra = {5'd2, 5'd1}; v.rf = {32'h22, 32'h11};
    v.e_op = {32'h22, 32'h11}; tv.push_back(v);
    // c2: or r4,r3,r0 with r3 forwarded from EX
    v = nv(B+8, B+4); v.ra = {5'd0, 5'd3}; v.rf = {32'h77, 32'h99};
    v.we = 3'b001; v.rdy = 3'b001; v.wa[0] = 5'd3; v.wd[0] = 32'h55;
    v.e_op = {32'h0, 32'h55}; tv.push_back(v);
    // c3: lw r5 in EX not ready -> interlock; port1 captured
    v = nv(B+12, B+8); v.ra = {5'd1, 5'd5}; v.rf = {32'h11, 32'h0};
    v.we = 3'b001; v.wa[0] = 5'd5; v.wd[0] = 32'hF0;
    v.e_st = 1; v.e_exv = 0; v.e_chk = 2'b10; v.e_op = {32'h11, 32'h0}; tv.push_back(v);
    // c4: load at MEM forwards 0xDEAD; port1 keeps captured 0x11
    v = nv(B+12, B+8); v.ra = {5'd1, 5'd5}; v.rf = {32'hBAD, 32'h0};
    v.we = 3'b010; v.rdy = 3'b010; v.wa[1] = 5'd5; v.wd[1] = 32'hDEAD;
    v.e_op = {32'h11, 32'hDEAD}; v.e_cnt = 1; tv.push_back(v);
    // c5..c8: hold with WB bypass r7 only in the first cycle
    for (int i = 0; i < 4; i++) begin
      v = nv(B+16, B+12); v.hd = (i < 3); v.ra = {5'd0, 5'd7};
      if (i == 0) begin v.we = 3'b100; v.rdy = 3'b100; v.wa[2] = 5'd7; v.wd[2] = 32'h1234; end
      v.e_op = {32'h0, 32'h1234}; v.e_cnt = 1; tv.push_back(v);
    end
    // c9: new instruction reads r7 -> capture released, stale rf 0
    v = nv(B+20, B+16); v.ra = {5'd0, 5'd7}; v.e_cnt = 1; tv.push_back(v);
    // c10: sources 0 and 2 both match r9 -> youngest wins
    v = nv(B+24, B+20); v.ra = {5'd9, 5'd9};
    v.we = 3'b101; v.rdy = 3'b101; v.wa[0] = 5'd9; v.wa[2] = 5'd9;
    v.wd[0] = 32'hA; v.wd[2] = 32'hB; v.e_op = {32'hA, 32'hA}; v.e_cnt = 1; tv.push_back(v);
    // c11: source 0 matches but not ready -> stall, source 2 ignored
    v = nv(B+28, B+24); v.ra = {5'd9, 5'd9};
    v.we = 3'b101; v.rdy = 3'b100; v.wa[0] = 5'd9; v.wa[2] = 5'd9;
    v.wd[0] = 32'hF0; v.wd[2] = 32'hB;
    v.e_st = 1; v.e_exv = 0; v.e_chk = 2'b00; v.e_cnt = 1; tv.push_back(v);
    // c12: source 1 now carries r9; still beats source 2
    v = nv(B+28, B+24); v.ra = {5'd9, 5'd9};
    v.we = 3'b110; v.rdy = 3'b110; v.wa[1] = 5'd9; v.wa[2] = 5'd9;
    v.wd[1] = 32'hC; v.wd[2] = 32'hB; v.e_op = {32'hC, 32'hC}; v.e_cnt = 2; tv.push_back(v);
    // c13: stall, port1 (unused r8) gets captured
    v = nv(B+32, B+28); v.ra = {5'd8, 5'd5}; v.ru = 2'b01; v.rf = {32'h88, 32'h0};
    v.we = 3'b001; v.wa[0] = 5'd5;
    v.e_st = 1; v.e_exv = 0; v.e_chk = 2'b10; v.e_op = {32'h88, 32'h0}; v.e_cnt = 2; tv.push_back(v);
    // c14: stall + flush + if_valid: flush wins
    v = nv(B+32, B+28); v.fl = 1; v.ra = {5'd8, 5'd5}; v.ru = 2'b01; v.rf = {32'h90, 32'h0};
    v.we = 3'b001; v.wa[0] = 5'd5;
    v.e_st = 1; v.e_exv = 0; v.e_chk = 2'b10; v.e_op = {32'h88, 32'h0}; v.e_cnt = 3; tv.push_back(v);
    // c15: ID empty, no stall, capture cleared (rf read through)
    v = nv(B+36, B+28); v.ra = {5'd8, 5'd5}; v.ru = 2'b01; v.rf = {32'h99, 32'h0};
    v.we = 3'b001; v.wa[0] = 5'd5;
    v.e_idv = 0; v.e_exv = 0; v.e_chk = 2'b10; v.e_op = {32'h99, 32'h0}; v.e_cnt = 4; tv.push_back(v);
    // c16: pending but unused port, held: no stall, no capture
    v = nv(B+40, B+36); v.hd = 1; v.ra = {5'd0, 5'd5}; v.ru = 2'b00; v.rf = {32'h0, 32'h66};
    v.we = 3'b001; v.wa[0] = 5'd5; v.wd[0] = 32'h3;
    v.e_chk = 2'b10; v.e_cnt = 4; tv.push_back(v);
    // c17: source gone -> regfile value, proves no capture happened
    v = nv(B+40, B+36); v.ra = {5'd0, 5'd5}; v.ru = 2'b00; v.rf = {32'h0, 32'h66};
    v.e_op = {32'h0, 32'h66}; v.e_cnt = 4; tv.push_back(v);

    // Reset held with IF offering an instruction
    if_valid = 1; if_pc = B; if_inst = ins(B);
    repeat (2) @(negedge clk);
    #1;
    chk("rst id_pc", id_pc, RPC);
    chk("rst id_valid", {31'b0, id_valid}, 0);
    chk("rst stallreq", {31'b0, stallreq}, 0);
    chk("rst ex_valid", {31'b0, ex_valid}, 0);
    chk("rst id_inst", id_inst, 0);
    chk("rst cnt", lu_stall_cnt, 0);

    foreach (tv[i]) begin
      @(negedge clk);
      rst = 1'b1;
      drive(tv[i]);
      #1;
      chk($sformatf("c%0d id_valid", i), {31'b0, id_valid}, {31'b0, tv[i].e_idv});
      chk($sformatf("c%0d id_pc", i), id_pc, tv[i].e_pc);
      chk($sformatf("c%0d id_inst", i), id_inst, tv[i].e_inst);
      chk($sformatf("c%0d stallreq", i), {31'b0, stallreq}, {31'b0, tv[i].e_st});
      chk($sformatf("c%0d ex_valid", i), {31'b0, ex_valid}, {31'b0, tv[i].e_exv});
      chk($sformatf("c%0d cnt", i), lu_stall_cnt, tv[i].e_cnt);
      for (int k = 0; k < 2; k++)
        if (tv[i].e_chk[k])
          chk($sformatf("c%0d opnd%0d", i, k), opnd[k*32 +: 32], tv[i].e_op[k]);
    end

    // Asynchronous reset in the middle of a load-use stall
    @(negedge clk);
    flush = 0; id_hold = 0; rd_addr = {5'd0, 5'd5}; rd_use = 2'b01;
    byp_we = 3'b001; byp_ready = 3'b000; byp_waddr = {10'd0, 5'd5};
    #1;
    chk("async pre stallreq", {31'b0, stallreq}, 1);
    #1 rst = 1'b0;
    #1;
    chk("async id_valid", {31'b0, id_valid}, 0);
    chk("async stallreq", {31'b0, stallreq}, 0);
    chk("async id_pc", id_pc, RPC);
    chk("async cnt", lu_stall_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/id_operand_stage.md
# id_operand_stage

Parametrised instruction-decode front stage: the IF→ID pipeline register plus an operand-resolution unit with NSRC bypass sources, NRD read ports, load-use interlock and stall-safe operand capture. It sits between IF and the decoder/EX bus packer. It fixes the lost-bypass hazard by latching each resolved operand while the instruction is held in ID. Decode itself stays external: the decoder reads `id_inst` and returns read addresses and use flags.

## Interface
- `NRD`, 2, number of register read ports
- `NSRC`, 3, number of bypass sources; index 0 is youngest (EX), NSRC-1 oldest (WB)
- `DW`, 32, data width
- `AW`, 5, register address width
- `RESET_PC`, 32'hBFBF_FFFC, reset value of `id_pc`

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `flush`  in  1  discard ID instruction
- `id_hold`  in  1  downstream stall; ID must keep its instruction
- `if_valid`  in  1  IF offers an instruction
- `if_pc`  in  32  IF PC
- `if_inst`  in  32  IF instruction word
- `rd_addr`  in  NRD*AW  read addresses from decoder; port k = bits [k*AW +: AW]
- `rd_use`  in  NRD  port k operand is actually consumed
- `rf_rdata`  in  NRD*DW  regfile combinational read data
- `byp_we`  in  NSRC  source s writes a register
- `byp_ready`  in  NSRC  source s data is valid (0 = load still in flight)
- `byp_waddr`  in  NSRC*AW  source s destination
- `byp_wdata`  in  NSRC*DW  source s data
- `id_valid`  out  1  ID holds a live instruction
- `id_pc`  out  32  registered PC
- `id_inst`  out  32  registered instruction
- `opnd`  out  NRD*DW  resolved operands
- `ex_valid`  out  1  instruction may issue to EX this cycle
- `stallreq`  out  1  load-use interlock request to stall controller
- `lu_stall_cnt`  out  32  count of interlock cycles

## Operation
- `adv = ~id_hold & ~stallreq`.
- Register priority each edge is reset, then `flush`, then `adv`, then hold:
  - Reset: all state cleared.
  - `flush`: `id_valid`←0 and all capture flags cleared; `id_pc`/`id_inst` keep their values.
  - `adv`: `id_valid`←`if_valid`, `id_pc`←`if_pc`, `id_inst`←`if_inst`, all capture flags cleared.
  - Otherwise: hold.
- Resolution per port k, evaluated in this order:
  - `rd_addr`=0 → `opnd`=0, never pending.
  - `cap_v[k]`=1 → `opnd`=`cap_d[k]`.
  - Otherwise take the lowest-index s with `byp_we[s]` and `byp_waddr[s]`=`rd_addr[k]`. If `byp_ready[s]`, `opnd`=`byp_wdata[s]`; if not, port k is pending. Older matching sources are never used while a younger one matches.
  - No bypass match → `opnd`=`rf_rdata[k]`.
- `stallreq = id_valid & |(rd_use & pending)`.
- `ex_valid = id_valid & ~stallreq`. EX inserts a bubble when this is low.
- Capture: on an edge with `id_valid`, `~adv` and `~flush`, each port with `cap_v[k]`=0 and not pending loads `cap_d[k]`←current `opnd[k]` and sets `cap_v[k]`←1. Captured values persist until the next advance or flush.
- `lu_stall_cnt` increments on each edge with `stallreq`=1. It wraps at 2^32.

## Timing
- Reset values: `id_valid` 0, `id_pc` RESET_PC, `id_inst` 0, `cap_v` 0, `cap_d` 0, `lu_stall_cnt` 0.
- Output reset values: `ex_valid` 0 and `stallreq` 0.
- `rst` is asynchronous: mid-stall assertion drops `id_valid` immediately, with no clock needed.
- IF→ID latency is 1 cycle.
- `rd_addr`→`opnd`/`stallreq` is combinational, within the same cycle.
- Load-use with the load in EX (source 0, not ready) costs 1 stall cycle when the load is ready at MEM.
- A load-use stall with `id_hold` also asserted: the instruction is held, and `stallreq` stays computed.
- `flush` together with `stallreq`: the flush wins, and `stallreq` deasserts next cycle.
- `flush` together with `if_valid`: the instruction is dropped; no capture occurs.
- `rd_use`=0 on a pending port does not stall. That port is still not captured while pending.

## Test plan
- Reset with `rst`=0 and `if_valid`=1: `id_pc`=BFBFFFFC, `id_valid`=0, `stallreq`=0. After release, `if_pc`=BFC00000 appears on `id_pc` 1 cycle later.
- `addu r3,r1,r2` followed by `or r4,r3,r0`, with source 0 carrying r3=0x55 ready: `opnd[0]`=0x55, `ex_valid`=1, no stall.
- `lw r5` in EX (`byp_ready[0]`=0, waddr 5) and ID reads r5 with `rd_use`=1: `stallreq`=1 for 1 cycle, `ex_valid`=0, `lu_stall_cnt` 0→1. Next cycle the source 1 value 0xDEAD is forwarded.
- `id_hold`=1 for 3 cycles while WB bypass (source 2) r7=0x1234 is present only in cycle 0, and `rf_rdata` stays stale 0: `opnd` stays 0x1234 in every held cycle (capture), and is released on advance.
- Sources 0 and 2 both match r9, with 0xA and 0xB respectively: `opnd`=0xA. If source 0 is not ready: stall, and 0xB is never used.
- `flush` asserted in the same cycle as `stallreq`=1: next cycle `id_valid`=0, `stallreq`=0, and `cap_v` is cleared.
